// File: rtl/sipo_rx_ctrl.sv
// Start/stop framed serial-to-parallel receiver with a one-word valid/ready output buffer.
// Define SIPO_RX_CTRL_PARITY_EN to add an even-parity bit after the data and a parity_err pulse.
module sipo_rx_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             sdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
`ifdef SIPO_RX_CTRL_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STOP   = 2'd2
`ifdef SIPO_RX_CTRL_PARITY_EN
    ,
    PARITY = 2'd3
`endif
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
`ifdef SIPO_RX_CTRL_PARITY_EN
  logic             par_bad_q;
  logic             parity_err_q;
`endif

  // NOTE: every register below, including the shift register and output word,
  // is in the async reset so a mid-frame reset leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low each cycle; later non-blocking writes in this
      // block override these defaults, so a pulse lasts exactly one clock.
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!sdata) begin
              cnt_q   <= '0;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            shift_q <= {shift_q[WIDTH-2:0], sdata};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_CTRL_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
`ifdef SIPO_RX_CTRL_PARITY_EN
          PARITY: begin
            // Even parity: data bits XOR parity bit must be 0.
            par_bad_q <= (^shift_q) ^ sdata;
            state_q   <= STOP;
          end
`endif
          STOP: begin
            state_q <= IDLE;
            if (!sdata) begin
              frame_err_q <= 1'b1;
`ifdef SIPO_RX_CTRL_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
`endif
            end else if (!out_valid_q || out_ready) begin
              out_data_q  <= shift_q;
              out_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SIPO_RX_CTRL_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboard bench for sipo_rx_ctrl (WIDTH=4): expected words queued at frame drive, checked on transfer.
module tb_sipo_rx_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_en = 1'b0;
  logic             sdata = 1'b1;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;
`ifdef SIPO_RX_CTRL_PARITY_EN
  logic             parity_err;
  logic             par_bit = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int busy_low = 0;
  int n_fe = 0, n_ov = 0, n_valid = 0, n_pe = 0;
  logic [WIDTH-1:0] exp_q[$];

  sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .sdata     (sdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef SIPO_RX_CTRL_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pulse/valid counters and scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (frame_err) n_fe++;
    if (overrun)   n_ov++;
    if (out_valid) n_valid++;
`ifdef SIPO_RX_CTRL_PARITY_EN
    if (parity_err) n_pe++;
`endif
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
      else                   check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_bit(input logic b, input int gap, input bit chk);
    bit_en = 1'b1;
    sdata  = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    sdata  = 1'b1;
    if (chk && !busy) busy_low++;
    repeat (gap) begin
      @(posedge clk); #1;
      if (chk && !busy) busy_low++;
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input int gap);
    send_bit(1'b0, gap, 1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i], gap, 1'b1);
`ifdef SIPO_RX_CTRL_PARITY_EN
    send_bit(par_bit, gap, 1'b1);
`endif
    send_bit(stop, gap, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_data"},  32'(out_data), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"},   32'(overrun), 32'd0);
`ifdef SIPO_RX_CTRL_PARITY_EN
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, fe0, ov0, pe0;

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame 1011, consumer always ready, valid exactly one cycle
    out_ready = 1'b1;
    v0 = n_valid;
`ifdef SIPO_RX_CTRL_PARITY_EN
    par_bit = 1'b1;
`endif
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 0);
    check("basic_latency_valid", 32'(out_valid), 32'd1);
    check("basic_busy_after", 32'(busy), 32'd0);
    idle_cycles(3);
    check("basic_valid_cycles", 32'(n_valid - v0), 32'd1);

    // Back-to-back frames with consumer stalled: second word dropped
    out_ready = 1'b0;
    ov0 = n_ov;
`ifdef SIPO_RX_CTRL_PARITY_EN
    par_bit = 1'b0;
`endif
    exp_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b1, 0);
    send_frame(4'b0011, 1'b1, 0);
    idle_cycles(2);
    check("ovr_pulses", 32'(n_ov - ov0), 32'd1);
    check("ovr_hold_data", 32'(out_data), 32'hC);
    check("ovr_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle_cycles(2);
    check("ovr_valid_cleared", 32'(out_valid), 32'd0);

    // Bad stop bit
    fe0 = n_fe;
    v0  = n_valid;
    send_frame(4'b1010, 1'b0, 0);
    idle_cycles(2);
    check("ferr_pulses", 32'(n_fe - fe0), 32'd1);
    check("ferr_no_valid", 32'(n_valid - v0), 32'd0);
    check("ferr_busy", 32'(busy), 32'd0);

    // Strobe every third cycle, busy held through the frame
    busy_low = 0;
    v0 = n_valid;
`ifdef SIPO_RX_CTRL_PARITY_EN
    par_bit = 1'b1;
`endif
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 2);
    idle_cycles(2);
    check("slow_busy_low", 32'(busy_low), 32'd0);
    check("slow_valid_cycles", 32'(n_valid - v0), 32'd1);

    // Mid-frame reset with a pending word, then a clean frame
    out_ready = 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
    par_bit = 1'b0;
`endif
    send_frame(4'b1001, 1'b1, 0);
    check("rst_pending_valid", 32'(out_valid), 32'd1);
    fe0 = n_fe;
    ov0 = n_ov;
    send_bit(1'b0, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    send_bit(1'b1, 0, 1'b1);
    check("rst_midframe_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 0);
    idle_cycles(2);
    check("rst_no_ferr", 32'(n_fe - fe0), 32'd0);
    check("rst_no_ovr", 32'(n_ov - ov0), 32'd0);

`ifdef SIPO_RX_CTRL_PARITY_EN
    // Parity: 0111 has odd data parity so the even parity bit must be 1
    pe0 = n_pe;
    v0  = n_valid;
    par_bit = 1'b0;
    send_frame(4'b0111, 1'b1, 0);
    idle_cycles(2);
    check("par_bad_pulse", 32'(n_pe - pe0), 32'd1);
    check("par_bad_no_load", 32'(n_valid - v0), 32'd0);
    par_bit = 1'b1;
    exp_q.push_back(4'b0111);
    send_frame(4'b0111, 1'b1, 0);
    idle_cycles(2);
    check("par_good_no_pulse", 32'(n_pe - pe0), 32'd1);
    fe0 = n_fe;
    par_bit = 1'b0;
    send_frame(4'b0111, 1'b0, 0);
    idle_cycles(2);
    check("par_ferr_only_fe", 32'(n_fe - fe0), 32'd1);
    check("par_ferr_only_pe", 32'(n_pe - pe0), 32'd1);
`else
    pe0 = n_pe;
    check("no_parity_counter", 32'(n_pe - pe0), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, the number of data bits per frame (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The module SHALL have port bit_en, input, 1, the bit strobe; sdata is sampled only in cycles where bit_en=1.
REQ-005 The module SHALL have port sdata, input, 1, the serial line, idle high.
REQ-006 The module SHALL have port out_data, output, WIDTH, the last accepted parallel word.
REQ-007 The module SHALL have port out_valid, output, 1, set while out_data holds an unconsumed word.
REQ-008 The module SHALL have port out_ready, input, 1, the consumer accept; a transfer occurs when out_valid=1 and out_ready=1.
REQ-009 The module SHALL have port busy, output, 1, which is 1 in any state other than IDLE.
REQ-010 The module SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-011 The module SHALL have port overrun, output, 1, a one-cycle pulse when a completed word is dropped.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY (macro builds only) and STOP.
REQ-013 In IDLE, when bit_en=1 and sdata=0 (start bit), the FSM SHALL clear the bit counter and go to SHIFT; when sdata=1 it SHALL stay in IDLE.
REQ-014 In SHIFT, each bit_en SHALL shift sdata into an internal WIDTH-bit shift register at bit 0, moving earlier bits toward WIDTH-1, so the first data bit ends in bit WIDTH-1.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; after the WIDTH-th data bit the FSM SHALL go to STOP, or to PARITY when the macro is defined.
REQ-016 In STOP, a bit_en with sdata=1 SHALL complete the frame; a bit_en with sdata=0 SHALL pulse frame_err and discard the word.
REQ-017 In both STOP cases the FSM SHALL return to IDLE; a new start bit SHALL be recognised on the next bit_en.
REQ-018 On completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, the module SHALL load out_data from the shift register and drive out_valid=1 on the following cycle (latency 1 clk from the stop-bit strobe).
REQ-019 On completion with out_valid=1 and out_ready=0, the module SHALL drop the new word, hold out_data, and pulse overrun.
REQ-020 A transfer with no simultaneous completion SHALL clear out_valid on the next cycle.
REQ-021 out_data SHALL change only on a load.
REQ-022 Cycles with bit_en=0 SHALL not change the FSM state, the counter or the shift register.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately, without a clock edge, force IDLE, counter=0, shift register=0, out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0 and parity_err=0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame, and no pulse SHALL be generated for it.
REQ-025 After rst_n deasserts, operation SHALL resume from IDLE on the next clk edge.

Configuration
REQ-026 When macro SIPO_RX_CTRL_PARITY_EN is defined, the module SHALL add output parity_err (1 bit, one-cycle pulse) and a PARITY state.
REQ-027 In PARITY, one bit_en SHALL sample an even-parity bit (XOR of the data bits and the parity bit = 0), then the FSM SHALL go to STOP.
REQ-028 With the macro, a parity mismatch SHALL pulse parity_err when STOP completes, and the word SHALL be discarded; a frame error in the same frame SHALL pulse only frame_err.
REQ-029 Without the macro, the parity_err port and the PARITY state SHALL not exist, and frames SHALL be start + WIDTH data + stop.

Verification (WIDTH=4, bit_en every cycle unless stated)
REQ-030 Reset, then sdata sequence 0,1,0,1,1,1 with out_ready=1 -> out_data=4'b1011 and out_valid=1 for exactly 1 cycle, starting 1 clk after the stop strobe.
REQ-031 Two back-to-back frames 4'b1100 then 4'b0011 with out_ready=0 -> first word held, overrun pulses once, out_data stays 4'b1100.
REQ-032 Stop bit 0 -> frame_err pulses 1 cycle, out_valid stays 0, FSM in IDLE, busy=0.
REQ-033 bit_en asserted every 3rd cycle -> same result as REQ-030, with busy high for the whole frame.
REQ-034 rst_n pulsed low after 2 data bits -> all outputs 0 immediately; a following full frame 4'b0110 is received correctly.
REQ-035 With SIPO_RX_CTRL_PARITY_EN, data 4'b0111 with parity bit 0 -> parity_err pulse and no load; with parity bit 1 -> out_data=4'b0111.
